mips_mem_access: RTL

Load/store bus unit between the MIPS I core's execute stage and the Avalon memory-mapped bus. It accepts one byte, halfword or word access request at a time and drives `address`/`read`/`write`/`byteenable`/`writedata`, holding them while `waitrequest` is high. It returns sign- or zero-extended load data to the core with a one-cycle `done` pulse. Byte order is little-endian throughout.

---
 rtl/mips_mem_access.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_access.sv
// Load/store bus unit: one byte/half/word access at a time onto an Avalon-MM master port.
// Build option MIPS_MEM_UNALIGNED_TRAP_EN turns misaligned half/word requests into error responses.
module mips_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] address_reg, address_next;
  logic        read_reg, read_next;
  logic        write_reg, write_next;
  logic [31:0] writedata_reg, writedata_next;
  logic [3:0]  byteenable_reg, byteenable_next;
  logic        we_reg, we_next;
  logic [1:0]  size_reg, size_next;
  logic        signed_reg, signed_next;
  logic [1:0]  lane_reg, lane_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;

  logic [7:0]  rd_byte [4];
  logic [3:0]  byte_be;
  logic [31:0] load_value;
  logic [15:0] wait_sat;
  logic        timeout_hit;
  logic        misaligned;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = readdata[8*gi +: 8];
      assign byte_be[gi] = (req_addr[1:0] == 2'(gi));
    end
  endgenerate

`ifdef MIPS_MEM_UNALIGNED_TRAP_EN
  assign misaligned = (req_size == 2'd1) ? req_addr[0]
                    : (req_size[1] ? (req_addr[1:0] != 2'b00) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif

  // Saturating wait count; timeout compares the count this cycle would reach.
  assign wait_sat    = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
  assign timeout_hit = (TIMEOUT_W != 32'd0) && ({16'd0, wait_sat} == TIMEOUT_W);

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    load_value = readdata;
    b = rd_byte[lane_reg];
    h = lane_reg[1] ? readdata[31:16] : readdata[15:0];
    case (size_reg)
      2'd0:    load_value = {{24{signed_reg & b[7]}}, b};
      2'd1:    load_value = {{16{signed_reg & h[15]}}, h};
      default: load_value = readdata;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;
    rdata_next      = rdata_reg;
    address_next    = address_reg;
    read_next       = read_reg;
    write_next      = write_reg;
    writedata_next  = writedata_reg;
    byteenable_next = byteenable_reg;
    we_next         = we_reg;
    size_next       = size_reg;
    signed_next     = signed_reg;
    lane_next       = lane_reg;
    wait_cnt_next   = wait_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (req) begin
          we_next      = req_we;
          size_next    = req_size;
          signed_next  = req_signed;
          lane_next    = req_addr[1:0];
          address_next = {req_addr[31:2], 2'b00};
          case (req_size)
            2'd0: begin
              byteenable_next = byte_be;
              writedata_next  = {4{req_wdata[7:0]}};
            end
            2'd1: begin
              byteenable_next = req_addr[1] ? 4'b1100 : 4'b0011;
              writedata_next  = {2{req_wdata[15:0]}};
            end
            default: begin
              byteenable_next = 4'b1111;
              writedata_next  = req_wdata;
            end
          endcase
          if (misaligned) begin
            state_next = RESP;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next    = BUS;
            read_next     = ~req_we;
            write_next    = req_we;
            wait_cnt_next = 16'd0;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          done_next  = 1'b1;
          state_next = RESP;
          if (!we_reg) rdata_next = load_value;
        end else begin
          wait_cnt_next = wait_sat;
          if (timeout_hit) begin
            read_next  = 1'b0;
            write_next = 1'b0;
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= 32'd0;
      address_reg    <= 32'd0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      writedata_reg  <= 32'd0;
      byteenable_reg <= 4'd0;
      we_reg         <= 1'b0;
      size_reg       <= 2'd0;
      signed_reg     <= 1'b0;
      lane_reg       <= 2'd0;
      wait_cnt_reg   <= 16'd0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      address_reg    <= address_next;
      read_reg       <= read_next;
      write_reg      <= write_next;
      writedata_reg  <= writedata_next;
      byteenable_reg <= byteenable_next;
      we_reg         <= we_next;
      size_reg       <= size_next;
      signed_reg     <= signed_next;
      lane_reg       <= lane_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign rdata      = rdata_reg;
  assign address    = address_reg;
  assign read       = read_reg;
  assign write      = write_reg;
  assign writedata  = writedata_reg;
  assign byteenable = byteenable_reg;

endmodule
